// File: rtl/seq_div4b_if.sv
// Start/busy/done handshake and operand/result bus for the sequential divider.
interface seq_div4b_if #(
    parameter int unsigned DVD_W = 4,
    parameter int unsigned DVS_W = 2
);
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;

    // Requester side: drives operands and start, observes status and results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div4b.sv
// Sequential restoring divider: one quotient bit per clock, MSB first,
// with a start/busy/done handshake. All outputs come straight from flops.
module seq_div4b #(
    parameter int unsigned DVD_W = 4,
    parameter int unsigned DVS_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_div4b_if.slave   bus
);

    localparam int unsigned CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] qw_q, qw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DVD_W-1:0] quot_q, quot_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Trial subtraction for the current bit. The partial remainder always
    // stays below the divisor, so DVS_W bits hold it; the trial value needs one more.
    logic [DVS_W:0]   t_c;
    logic             ge_c;
    logic [DVS_W-1:0] p_new_c;

    // Restoring step datapath.
    always_comb begin
        t_c     = {p_q, dvd_q[cnt_q]};
        ge_c    = (t_c >= {1'b0, dvs_q});
        p_new_c = ge_c ? DVS_W'(t_c - {1'b0, dvs_q}) : t_c[DVS_W-1:0];
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            qw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            qw_q    <= qw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        qw_d    = qw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.divisor != '0) begin
                        dvd_d   = bus.dividend;
                        dvs_d   = bus.divisor;
                        p_d     = '0;
                        qw_d    = '0;
                        cnt_d   = CNT_W'(DVD_W - 1);
                        state_d = RUN;
                    end else begin
                        // Divide by zero skips RUN and reports all-ones quotient.
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                qw_d[cnt_q] = ge_c;
                p_d         = p_new_c;
                if (cnt_q == '0) begin
                    quot_d  = qw_d;
                    rem_d   = p_new_c;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // Start is ignored here; busy drops as we leave.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule
